// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: scans operands MSB chunk first and stops at the first differing chunk.
// Optional two's-complement ordering is enabled with macro SEQ_COMPARE_SIGNED_EN.
module seq_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             signed_op,
    input  logic [2:0]       bonus_control_in,
    output logic             busy,
    output logic             valid,
    output logic             less,
    output logic             equal,
    output logic [2:0]       bonus_control
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [2:0]        bc_q, bc_d;
    logic              less_q, less_d;
    logic              equal_q, equal_d;
    logic [2:0]        bc_out_q, bc_out_d;

    logic [WIDTH-1:0]  a_cmp, b_cmp;
    logic [CHUNK-1:0]  a_chunk, b_chunk;

`ifdef SEQ_COMPARE_SIGNED_EN
    logic              sgn_q, sgn_d;

    // Flipping the sign bit maps two's-complement order onto unsigned order;
    // the sign bit only lives in the top chunk, so flipping it unconditionally is safe.
    assign a_cmp = a_q ^ {sgn_q, {(WIDTH-1){1'b0}}};
    assign b_cmp = b_q ^ {sgn_q, {(WIDTH-1){1'b0}}};
`else
    logic              unused_signed_op;

    assign unused_signed_op = signed_op;
    assign a_cmp = a_q;
    assign b_cmp = b_q;
`endif

    assign a_chunk = a_cmp[idx_q*CHUNK +: CHUNK];
    assign b_chunk = b_cmp[idx_q*CHUNK +: CHUNK];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        bc_d     = bc_q;
        less_d   = less_q;
        equal_d  = equal_q;
        bc_out_d = bc_out_q;
`ifdef SEQ_COMPARE_SIGNED_EN
        sgn_d    = sgn_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = src1;
                    b_d     = src2;
                    bc_d    = bonus_control_in;
                    idx_d   = IW'(NCHUNK - 1);
                    state_d = SCAN;
`ifdef SEQ_COMPARE_SIGNED_EN
                    sgn_d   = signed_op;
`endif
                end
            end
            SCAN: begin
                if (a_chunk != b_chunk) begin
                    less_d   = (a_chunk < b_chunk);
                    equal_d  = 1'b0;
                    bc_out_d = bc_q;
                    state_d  = DONE;
                end else if (idx_q == '0) begin
                    less_d   = 1'b0;
                    equal_d  = 1'b1;
                    bc_out_d = bc_q;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            bc_q     <= 3'b000;
            less_q   <= 1'b0;
            equal_q  <= 1'b0;
            bc_out_q <= 3'b000;
`ifdef SEQ_COMPARE_SIGNED_EN
            sgn_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            bc_q     <= bc_d;
            less_q   <= less_d;
            equal_q  <= equal_d;
            bc_out_q <= bc_out_d;
`ifdef SEQ_COMPARE_SIGNED_EN
            sgn_q    <= sgn_d;
`endif
        end
    end

    assign busy          = (state_q == SCAN);
    assign valid         = (state_q == DONE);
    assign less          = less_q;
    assign equal         = equal_q;
    assign bonus_control = bc_out_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Scoreboard bench for seq_comparator: stimulus pushes expected results, a negedge monitor pops and checks them.
module tb_seq_comparator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src1, src2;
    logic        signed_op;
    logic [2:0]  bonus_control_in;
    logic        busy, valid, less, equal;
    logic [2:0]  bonus_control;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       less;
        logic       eq;
        logic [2:0] bc;
        int         k;
    } exp_t;

    exp_t exp_q[$];

`ifdef SEQ_COMPARE_SIGNED_EN
    localparam logic SGN_LESS = 1'b1;
`else
    localparam logic SGN_LESS = 1'b0;
`endif

    seq_comparator #(.WIDTH(32), .CHUNK(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .src1             (src1),
        .src2             (src2),
        .signed_op        (signed_op),
        .bonus_control_in (bonus_control_in),
        .busy             (busy),
        .valid            (valid),
        .less             (less),
        .equal            (equal),
        .bonus_control    (bonus_control)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: latency counted in busy cycles; outputs must hold the prior result while scanning.
    logic       last_less = 1'b0, last_eq = 1'b0, prev_valid = 1'b0;
    logic [2:0] last_bc = 3'b000;
    int         busy_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            last_less  = 1'b0;
            last_eq    = 1'b0;
            last_bc    = 3'b000;
            busy_cnt   = 0;
            prev_valid = 1'b0;
        end else begin
            if (busy) begin
                busy_cnt++;
                check("hold_less", {31'd0, less}, {31'd0, last_less});
                check("hold_equal", {31'd0, equal}, {31'd0, last_eq});
                check("hold_bc", {29'd0, bonus_control}, {29'd0, last_bc});
                check("valid_in_scan", {31'd0, valid}, 32'd0);
            end
            if (valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("less", {31'd0, less}, {31'd0, e.less});
                    check("equal", {31'd0, equal}, {31'd0, e.eq});
                    check("bonus_control", {29'd0, bonus_control}, {29'd0, e.bc});
                    check("latency", busy_cnt, e.k);
                    last_less = e.less;
                    last_eq   = e.eq;
                    last_bc   = e.bc;
                end
                busy_cnt = 0;
            end
            prev_valid = valid;
        end
    end

    // All stimulus runs in the phase #1 after a rising edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [2:0] bc, input logic el, input logic ee, input int k);
        exp_t e;
        e.less = el;
        e.eq   = ee;
        e.bc   = bc;
        e.k    = k;
        exp_q.push_back(e);
        src1             = a;
        src2             = b;
        signed_op        = s;
        bonus_control_in = bc;
        start            = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (valid) break;
            @(posedge clk);
            #1;
        end
        check("done_timeout", {31'd0, valid}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        start            = 1'b1;
        src1             = 32'hDEADBEEF;
        src2             = 32'h0BADF00D;
        signed_op        = 1'b0;
        bonus_control_in = 3'b111;

        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_valid", {31'd0, valid}, 32'd0);
            check("rst_less", {31'd0, less}, 32'd0);
            check("rst_equal", {31'd0, equal}, 32'd0);
            check("rst_bc", {29'd0, bonus_control}, 32'd0);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", {31'd0, busy}, 32'd0);

        issue(32'h00000005, 32'h00000007, 1'b0, 3'b010, 1'b1, 1'b0, 4);
        wait_done();
        issue(32'h80000000, 32'h00000001, 1'b0, 3'b101, 1'b0, 1'b0, 1);
        wait_done();
        issue(32'h80000000, 32'h00000001, 1'b1, 3'b011, SGN_LESS, 1'b0, 1);
        wait_done();
        issue(32'h12345678, 32'h12345678, 1'b0, 3'b111, 1'b0, 1'b1, 4);
        wait_done();

        // Start pulsed during SCAN must be ignored.
        issue(32'h00010000, 32'h00020000, 1'b0, 3'b100, 1'b1, 1'b0, 2);
        src1             = 32'hFF000000;
        src2             = 32'h00000000;
        bonus_control_in = 3'b001;
        start            = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        // Reset in the second SCAN cycle aborts the scan.
        src1             = 32'h00000001;
        src2             = 32'h00000002;
        bonus_control_in = 3'b110;
        start            = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_less", {31'd0, less}, 32'd0);
        check("abort_equal", {31'd0, equal}, 32'd0);
        check("abort_bc", {29'd0, bonus_control}, 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_stays_idle", {30'd0, busy, valid}, 32'd0);

        // Back-to-back: new start accepted while in DONE.
        issue(32'h00000005, 32'h00000007, 1'b0, 3'b001, 1'b1, 1'b0, 4);
        for (int i = 0; i < 20; i++) begin
            if (valid) break;
            @(posedge clk);
            #1;
        end
        check("b2b_first_done", {31'd0, valid}, 32'd1);
        issue(32'h00000002, 32'h00000001, 1'b0, 3'b110, 1'b0, 1'b0, 4);
        check("b2b_valid_drop", {31'd0, valid}, 32'd0);
        check("b2b_less_held", {31'd0, less}, 32'd1);
        wait_done();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_comparator.md
# seq_comparator

Multi-cycle magnitude comparator that sits directly upstream of the compare/bonus-select stage. It scans two operands chunk by chunk from the MSB down and stops at the first differing chunk. It then produces the registered `less`/`equal` flags together with the captured 3-bit bonus control code, which the compare stage consumes. It trades latency for a narrow per-cycle comparator and holds its result stable until the next request.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; NCHUNK = WIDTH/CHUNK.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only when busy=0.
- src1  input  WIDTH  operand A.
- src2  input  WIDTH  operand B.
- signed_op  input  1  1 = two's-complement compare (see Configuration).
- bonus_control_in  input  3  compare-mode code, captured with the operands.
- busy  output  1  high while scanning.
- valid  output  1  result valid; held until the next accepted start or reset.
- less  output  1  A < B (registered).
- equal  output  1  A == B (registered).
- bonus_control  output  3  captured code, aligned with less/equal.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: start=1 -> capture src1, src2, signed_op, bonus_control_in; idx := NCHUNK-1; go to SCAN. start=0 -> stay.
- SCAN: compare chunk idx of A and B, treating each chunk as unsigned.
  - Chunks differ -> less := (A_chunk < B_chunk); equal := 0; go to DONE.
  - Chunks are equal and idx=0 -> less := 0; equal := 1; go to DONE.
  - Otherwise -> idx := idx-1; stay in SCAN.
- DONE: valid=1. start=1 -> capture new operands, clear valid, go to SCAN with idx := NCHUNK-1 (back-to-back). Otherwise hold.
- start while busy=1 is ignored. Captured operands do not change during SCAN.
- busy=1 exactly in SCAN. valid=1 exactly in DONE.
- less, equal and bonus_control change only on entry to DONE or on reset. They are never driven during SCAN and keep the prior result until the new one is written.
- Reset values: state=IDLE, idx=0, busy=0, valid=0, less=0, equal=0, bonus_control=3'b000.
- rst has priority over every transition. Asserting it mid-SCAN aborts the scan and returns to IDLE on the next edge with all outputs at their reset values.

## Timing
- start is sampled at edge E0. The first chunk is compared during the cycle after E0.
- If the scan terminates on the k-th chunk examined (1 <= k <= NCHUNK), valid rises after edge E0+k.
  - Minimum latency: 1 cycle after capture (MSB chunk differs).
  - Maximum latency: NCHUNK cycles (operands equal, or they differ only in chunk 0).
- Back-to-back: a start accepted in DONE at edge E causes valid=0 after E. The next result follows the same latency rule.
- There are no combinational paths from inputs to outputs.

## Configuration
- Macro SEQ_COMPARE_SIGNED_EN.
- Defined: when the captured signed_op=1, the MSB of both operands is inverted before the top chunk (idx=NCHUNK-1) is compared. This yields a two's-complement ordering with unchanged latency.
- Undefined: signed_op is ignored and all compares are unsigned. The port remains present.

## Test plan
- Reset: assert rst for 2 cycles with start=1 -> busy=0, valid=0, less=0, equal=0, bonus_control=000. State stays IDLE while rst=1.
- Low-chunk difference: src1=0x00000005, src2=0x00000007, unsigned, bonus_control_in=3'b010, start at E0 -> valid rises after E0+4 with less=1, equal=0, bonus_control=010; busy is high for 4 cycles.
- MSB early exit: src1=0x80000000, src2=0x00000001.
  - unsigned -> valid after E0+1, less=0, equal=0.
  - signed_op=1 with the macro defined -> less=1; with the macro undefined -> less=0.
- Equal operands: src1=src2=0x12345678 -> valid after E0+4, equal=1, less=0.
- Ignore and abort:
  - start pulsed during SCAN with different operands -> result reflects the first operands only.
  - rst asserted at the 2nd SCAN cycle -> IDLE after that edge, valid stays 0, outputs at reset values.
- Back-to-back: in DONE, start with src1=0x00000002, src2=0x00000001 -> valid drops after that edge and rises 4 cycles later with less=0, equal=0; the previous less/equal hold until then.
